// File: rtl/alu_pkg.sv
// Shared definitions for the Y86-64 execute ALU: function codes and condition-code layout.
package alu_pkg;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_XOR = 3;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational Y86 ALU: ADD/SUB/AND/XOR selected by ifun, with ZF/SF/OF derived from the result.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;
  localparam logic [OPW-1:0] OP_ADD = OPW'(ALU_ADD);
  localparam logic [OPW-1:0] OP_SUB = OPW'(ALU_SUB);
  localparam logic [OPW-1:0] OP_AND = OPW'(ALU_AND);
  localparam logic [OPW-1:0] OP_XOR = OPW'(ALU_XOR);

  // SUB follows Y86 operand order (valB - valA); the carry out of the MSB is dropped.
  always_comb begin
    result  = '0;
    of      = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        result = b + a;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = b - a;
        of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: illegal = 1'b1;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[MSB];

endmodule

// File: rtl/alu_pipe_cc.sv
// Registered ALU stage: input/output handshake, one-deep output register and the CC register.
module alu_pipe_cc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a producer holding
  // valid keeps its payload stable until that edge, and ready never depends on in_valid.
  logic             accept;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  cc_t              cc_q, cc_d;

  logic [WIDTH-1:0] core_result;
  logic             core_zf, core_sf, core_of, core_illegal;

  alu_core #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_core (
    .a      (in_a),
    .b      (in_b),
    .op     (in_op),
    .result (core_result),
    .zf     (core_zf),
    .sf     (core_sf),
    .of     (core_of),
    .illegal(core_illegal)
  );

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // CC follows accepted ops directly, so output backpressure never delays it.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      err_d       = core_illegal;
      if (in_set_cc && !core_illegal) begin
        cc_d = '{zf: core_zf, sf: core_sf, of: core_of};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_err    = err_q;
  assign cc_zf      = cc_q.zf;
  assign cc_sf      = cc_q.sf;
  assign cc_of      = cc_q.of;

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Bench for alu_pipe_cc: vector table, directed handshake sequences and a random sweep.
module tb_alu_pipe_cc;

  localparam int W  = 64;
  localparam int PW = W + 4;  // packet: {result, err, zf, sf, of}

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_op;
  logic          in_set_cc;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_err;
  logic          cc_zf, cc_sf, cc_of;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];
  logic [2:0]    model_cc = 3'b100;

  alu_pipe_cc #(.WIDTH(W), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_set_cc (in_set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_err   (out_err),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Golden model using widened signed arithmetic for overflow.
  function automatic logic [PW-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op, input logic sc,
                                           input logic [2:0] cur);
    logic [W:0]   w;
    logic [W-1:0] r;
    logic         o;
    logic [2:0]   nc;
    w = '0;
    o = 1'b0;
    case (op)
      4'd0: begin w = {a[W-1], a} + {b[W-1], b}; r = w[W-1:0]; o = w[W] ^ w[W-1]; end
      4'd1: begin w = {b[W-1], b} - {a[W-1], a}; r = w[W-1:0]; o = w[W] ^ w[W-1]; end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      default: return {{W{1'b0}}, 1'b1, cur};
    endcase
    nc = sc ? {(r == '0), r[W-1], o} : cur;
    return {r, 1'b0, nc};
  endfunction

  // driver: call at #1 after a posedge; returns #1 after the accepting posedge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                      input logic sc, input logic [PW-1:0] exp);
    logic acc;
    in_a = a; in_b = b; in_op = op; in_set_cc = sc; in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc) begin
      exp_q.push_back(exp);
      model_cc = exp[2:0];
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never rose for op %0d", op);
    end
    #1 in_valid = 1'b0;
  endtask

  // scoreboard monitor: compare whenever a result leaves the output register
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with empty queue", out_result);
        end else begin
          check("out_pkt", {out_result, out_err, cc_zf, cc_sf, cc_of}, exp_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    op;
    logic          sc;
    logic [W-1:0]  exp_r;
    logic          exp_err;
    logic [2:0]    exp_cc;  // {zf, sf, of}
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    logic         rsc;

    vecs[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 3'b011};
    vecs[1] = '{64'h5, 64'h5, 4'd1, 1'b1, 64'h0, 1'b0, 3'b100};
    vecs[2] = '{64'hFF, 64'hFF, 4'd3, 1'b0, 64'h0, 1'b0, 3'b100};
    vecs[3] = '{64'h1, 64'h2, 4'd4, 1'b1, 64'h0, 1'b1, 3'b100};
    vecs[4] = '{64'hF0F0, 64'h0FF0, 4'd2, 1'b1, 64'h00F0, 1'b0, 3'b000};
    vecs[5] = '{64'h1, 64'h0, 4'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b010};
    vecs[6] = '{64'h1, 64'h8000_0000_0000_0000, 4'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd0, 1'b1, 64'h0, 1'b0, 3'b100};
    vecs[8] = '{64'h3, 64'h4, 4'd15, 1'b1, 64'h0, 1'b1, 3'b100};
    vecs[9] = '{64'h8000_0000_0000_0000, 64'h1, 4'd3, 1'b1, 64'h8000_0000_0000_0001, 1'b0, 3'b010};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_set_cc = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {{(PW-1){1'b0}}, in_ready}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", {{(PW-1){1'b0}}, out_valid}, '0);
    check("reset_pkt", {out_result, out_err, cc_zf, cc_sf, cc_of}, {{W{1'b0}}, 1'b0, 3'b100});
    check("reset_ready", {{(PW-1){1'b0}}, in_ready}, {{(PW-1){1'b0}}, 1'b1});
    @(posedge clk);
    #1;

    // vector table, back to back
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sc,
           {vecs[i].exp_r, vecs[i].exp_err, vecs[i].exp_cc});
    end
    @(posedge clk);
    #1;

    // backpressure: hold result for 3 cycles, then drain and load on the same edge
    out_ready = 1'b0;
    send(64'd3, 64'd4, 4'd0, 1'b1, {64'd7, 1'b0, 3'b000});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) held = out_result;
      check("bp_in_ready", {{(PW-1){1'b0}}, in_ready}, '0);
      check("bp_valid", {{(PW-1){1'b0}}, out_valid}, {{(PW-1){1'b0}}, 1'b1});
      check("bp_result", {out_result, 4'b0}, {64'd7, 4'b0});
      check("bp_stable", {out_result, 4'b0}, {held, 4'b0});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(64'd9, 64'd2, 4'd1, 1'b1, {64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 3'b010});
    @(negedge clk);
    check("no_gap_valid", {{(PW-1){1'b0}}, out_valid}, {{(PW-1){1'b0}}, 1'b1});
    @(posedge clk);
    #1;

    // random sweep against the golden model
    for (int i = 0; i < 200; i++) begin
      ra  = W'($urandom_range(1, 256));
      rb  = W'($urandom_range(1, 256));
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      rsc = 1'($urandom_range(0, 1));
      send(ra, rb, rop, rsc, golden(ra, rb, rop, rsc, model_cc));
    end

    // mid-stream reset discards the held result and restores CC
    send(64'd10, 64'd1, 4'd1, 1'b1, golden(64'd10, 64'd1, 4'd1, 1'b1, model_cc));
    rst = 1'b1;
    exp_q.delete();
    model_cc = 3'b100;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", {{(PW-1){1'b0}}, out_valid}, '0);
    check("midrst_pkt", {out_result, out_err, cc_zf, cc_sf, cc_of}, {{W{1'b0}}, 1'b0, 3'b100});
    @(posedge clk);
    #1;
    send(64'd2, 64'd40, 4'd0, 1'b0, golden(64'd2, 64'd40, 4'd0, 1'b0, model_cc));

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", PW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
